nv_nvdla_skid_pipe_n: RTL and testbench
=======================================

# nv_nvdla_skid_pipe_n

Parametrised valid/ready pipe that chains `STAGES` identical skid-plus-pipe register slices over a `DW`-bit payload. It replaces the fixed 515-bit single-slice pipes in the DMA request paths, for example CDP WDMA to the DMA interface. Both `in_rdy` and `out_vld` are fully registered at every slice, so the block breaks both the forward and the backward timing paths. It adds a synchronous flush and an optional stall counter.

## Interface
- `DW`, 515: payload width in bits, 1..1024.
- `STAGES`, 1: number of chained slices, 1..4.
- `nvdla_core_clk` input 1: core clock, all flops on rising edge.
- `nvdla_core_rstn` input 1: asynchronous active-low reset.
- `in_vld` input 1: upstream request valid.
- `in_rdy` output 1: upstream ready; a registered flop of slice 0.
- `in_pd` input DW: upstream payload.
- `out_vld` output 1: downstream valid; the pipe-valid flop of the last slice.
- `out_rdy` input 1: downstream ready.
- `out_pd` output DW: downstream payload; the pipe-data flop of the last slice.
- `flush` input 1: synchronous drop of all held entries.
- `stall_cnt` output 32: cycles with `out_vld && !out_rdy`. Present only with `NVDLA_SKID_PIPE_STALL_CNT_EN`.

## Operation
Per-slice state:
- `skid_rdy_flop`: reset 1.
- `skid_vld`: reset 0.
- `skid_pd`: no reset.
- `pipe_vld`: reset 0.
- `pipe_pd`: no reset.

Per-slice combinational terms, where `i_*` are the slice inputs and `o_rdy` is the ready from the next slice or `out_rdy`:
- `pipe_rdy_bc = o_rdy || !pipe_vld`.
- `catch = i_vld && skid_rdy_flop && !pipe_rdy_bc`.
- Next `skid_vld`:
  - if `skid_vld` is set: `!pipe_rdy_bc`;
  - otherwise: `catch`.
- Next `skid_rdy_flop`:
  - if `skid_vld` is set: `pipe_rdy_bc`;
  - otherwise: `!catch`.
- `skid_pd` loads `i_pd` on `catch`.
- `sp_vld` and `sp_pd` come from the upstream input when `skid_rdy_flop` is 1, otherwise from the skid.
- Next `pipe_vld`:
  - if `pipe_rdy_bc`: `sp_vld`;
  - otherwise: hold at 1.
- `pipe_pd` loads `sp_pd` when `pipe_rdy_bc && sp_vld`.
- Slice k's `pipe_vld`/`pipe_pd` drive slice k+1's `i_vld`/`i_pd`. Slice k+1's `skid_rdy_flop` is slice k's `o_rdy`.

Handshake rules:
- A transfer occurs on a cycle where vld && rdy at either port.
- Payload order is preserved; there is no loss and no duplication.
- Capacity is 2×`STAGES` entries.

Flush behaviour:
- In the flush cycle, output handshakes still complete.
- An input accepted in the flush cycle is discarded.
- Next cycle, every `skid_vld`/`pipe_vld` is 0 and every `skid_rdy_flop` is 1.
- Data flops are untouched.

Reset:
- Asynchronous reset mid-transfer drops all entries immediately.
- Outputs during and after reset: `in_rdy`=1, `out_vld`=0, `out_pd` undefined (not checked while `out_vld`=0), `stall_cnt`=0.

## Timing
- Latency: `in` accept to `out_vld` is `STAGES` cycles when the pipe is empty and `out_rdy` is held 1.
- Throughput: 1 transfer per cycle sustained.
- Backpressure propagation: `out_rdy` deasserting lowers `in_rdy` after at most `STAGES` cycles. Each slice's skid absorbs the one in-flight beat.
- No combinational path exists from `out_rdy` to `in_rdy`, or from `in_vld`/`in_pd` to `out_*`.
- Simultaneous catch and drain in one slice resolves by the next-state equations above; the skid is never overwritten while `skid_vld`=1.

## Configuration
Macro `NVDLA_SKID_PIPE_STALL_CNT_EN`.

When defined:
- 32-bit `stall_cnt` increments on each cycle with `out_vld && !out_rdy`.
- It saturates at 0xFFFFFFFF.
- It clears to 0 on `flush`; clear takes priority over increment in the same cycle.

When undefined:
- The port and counter are absent.
- Behaviour is otherwise identical.

## Structure
- Shared package `nv_nvdla_skid_pipe_pkg` holds:
  - `SKID_PIPE_MAX_STAGES`=4;
  - `SKID_PIPE_MAX_DW`=1024;
  - `STALL_CNT_W`=32.
- Parameter legality is checked against these at elaboration.
- Sub-module `nv_nvdla_skid_pipe_stage` implements one slice, including the flush input. The top instantiates it `STAGES` times in a generate loop and adds the optional counter.

## Test plan
- **Reset:** hold `nvdla_core_rstn`=0 for 3 cycles → `in_rdy`=1, `out_vld`=0, `stall_cnt`=0. Release, send 0x1A5 with `STAGES`=3 and `out_rdy`=1 → `out_vld`=1 with `out_pd`=0x1A5 exactly 3 cycles after accept.
- **Streaming:** `STAGES`=2, 100 back-to-back beats with payloads 0..99 and `out_rdy`=1 → 100 outputs in order, one per cycle, starting at cycle 2.
- **Backpressure:** `STAGES`=2, `out_rdy`=0 while `in_vld`=1 every cycle → exactly 4 beats accepted, then `in_rdy`=0. Raise `out_rdy` → the 4 beats drain in order, and `in_rdy` returns to 1 within 2 cycles.
- **Random traffic:** random `in_vld`/`out_rdy` at 50% each for 10k cycles, `DW`=8 → scoreboard shows no loss, no duplicate, order preserved, and occupancy never exceeds 2×`STAGES`.
- **Flush:** fill with 3 entries, assert `flush` for 1 cycle with `in_vld`=1 → next cycle `out_vld`=0 and `in_rdy`=1, and the beat accepted in the flush cycle never appears at the output.
- **Stall counter (macro defined):**
  - `out_vld`=1 with `out_rdy`=0 for 7 cycles → `stall_cnt`=7;
  - `flush` → 0;
  - force the counter to 0xFFFFFFFE and stall 3 cycles → 0xFFFFFFFF.

Source files
------------

// File: rtl/nv_nvdla_skid_pipe_pkg.sv
// Shared constants and helpers for the chained skid/pipe valid-ready slice.
// Limits are checked when nv_nvdla_skid_pipe_n is elaborated.
package nv_nvdla_skid_pipe_pkg;

   localparam int SKID_PIPE_MAX_STAGES = 4;
   localparam int SKID_PIPE_MAX_DW     = 1024;
   localparam int STALL_CNT_W          = 32;

   function automatic bit skid_pipe_cfg_ok(input int dw, input int stages);
      return (dw >= 1) && (dw <= SKID_PIPE_MAX_DW) &&
             (stages >= 1) && (stages <= SKID_PIPE_MAX_STAGES);
   endfunction

   // The counter holds at all-ones instead of wrapping back to zero.
   function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(input logic [STALL_CNT_W-1:0] cnt);
      if (&cnt) begin
         return cnt;
      end else begin
         return cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/nv_nvdla_skid_pipe_stage.sv
// One skid-plus-pipe register slice. up_rdy and dn_vld/dn_pd are flops, so the
// slice breaks both the forward and the backward timing paths.
module nv_nvdla_skid_pipe_stage
   import nv_nvdla_skid_pipe_pkg::*;
#(
   parameter int DW = 515
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          up_vld,
   input  logic [DW-1:0] up_pd,
   output logic          up_rdy,
   output logic          dn_vld,
   output logic [DW-1:0] dn_pd,
   input  logic          dn_rdy
);

   logic          skid_rdy_r;
   logic          skid_vld_r;
   logic [DW-1:0] skid_pd_r;
   logic          pipe_vld_r;
   logic [DW-1:0] pipe_pd_r;

   logic          pipe_rdy_bc_s;
   logic          catch_s;
   logic          skid_vld_nxt_s;
   logic          skid_rdy_nxt_s;
   logic          sp_vld_s;
   logic [DW-1:0] sp_pd_s;
   logic          pipe_vld_nxt_s;

   // Next-state terms for the skid and pipe registers.
   always_comb begin
      pipe_rdy_bc_s  = 1'b0;
      catch_s        = 1'b0;
      skid_vld_nxt_s = 1'b0;
      skid_rdy_nxt_s = 1'b1;
      sp_vld_s       = 1'b0;
      sp_pd_s        = {DW{1'b0}};
      pipe_vld_nxt_s = 1'b0;

      pipe_rdy_bc_s = dn_rdy | ~pipe_vld_r;
      catch_s       = up_vld & skid_rdy_r & ~pipe_rdy_bc_s;

      // A full skid only drains; it is never reloaded while it holds a beat.
      if (skid_vld_r) begin
         skid_vld_nxt_s = ~pipe_rdy_bc_s;
         skid_rdy_nxt_s = pipe_rdy_bc_s;
      end else begin
         skid_vld_nxt_s = catch_s;
         skid_rdy_nxt_s = ~catch_s;
      end

      if (skid_rdy_r) begin
         sp_vld_s = up_vld;
         sp_pd_s  = up_pd;
      end else begin
         sp_vld_s = skid_vld_r;
         sp_pd_s  = skid_pd_r;
      end

      if (pipe_rdy_bc_s) begin
         pipe_vld_nxt_s = sp_vld_s;
      end else begin
         pipe_vld_nxt_s = 1'b1;
      end
   end

   // Control flops: async reset, flush empties the slice on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_rdy_r <= 1'b1;
         skid_vld_r <= 1'b0;
         pipe_vld_r <= 1'b0;
      end else if (flush) begin
         skid_rdy_r <= 1'b1;
         skid_vld_r <= 1'b0;
         pipe_vld_r <= 1'b0;
      end else begin
         skid_rdy_r <= skid_rdy_nxt_s;
         skid_vld_r <= skid_vld_nxt_s;
         pipe_vld_r <= pipe_vld_nxt_s;
      end
   end

   // Payload flops carry no reset; a flush leaves them untouched.
   always_ff @(posedge clk) begin
      if (catch_s && !flush) begin
         skid_pd_r <= up_pd;
      end
      if (pipe_rdy_bc_s && sp_vld_s && !flush) begin
         pipe_pd_r <= sp_pd_s;
      end
   end

   assign up_rdy = skid_rdy_r;
   assign dn_vld = pipe_vld_r;
   assign dn_pd  = pipe_pd_r;

endmodule

// File: rtl/nv_nvdla_skid_pipe_n.sv
// STAGES chained skid/pipe slices over a DW-bit payload with synchronous flush.
// Defining NVDLA_SKID_PIPE_STALL_CNT_EN adds the saturating stall_cnt output.
module nv_nvdla_skid_pipe_n
   import nv_nvdla_skid_pipe_pkg::*;
#(
   parameter int DW     = 515,
   parameter int STAGES = 1
)
(
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_pd,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_pd,
   input  logic          flush
`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   if (!skid_pipe_cfg_ok(DW, STAGES)) begin : g_bad_cfg
      $error("nv_nvdla_skid_pipe_n: DW or STAGES out of range");
   end

   // Index k is the input of slice k; index STAGES is the pipe output.
   logic [STAGES:0] vld_chain_s;
   logic [STAGES:0] rdy_chain_s;
   logic [DW-1:0]   pd_chain_s [STAGES+1];

   assign vld_chain_s[0]      = in_vld;
   assign pd_chain_s[0]       = in_pd;
   assign rdy_chain_s[STAGES] = out_rdy;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      nv_nvdla_skid_pipe_stage #(
         .DW (DW)
      ) u_stage (
         .clk    (nvdla_core_clk),
         .rst_n  (nvdla_core_rstn),
         .flush  (flush),
         .up_vld (vld_chain_s[k]),
         .up_pd  (pd_chain_s[k]),
         .up_rdy (rdy_chain_s[k]),
         .dn_vld (vld_chain_s[k+1]),
         .dn_pd  (pd_chain_s[k+1]),
         .dn_rdy (rdy_chain_s[k+1])
      );
   end

   assign in_rdy  = rdy_chain_s[0];
   assign out_vld = vld_chain_s[STAGES];
   assign out_pd  = pd_chain_s[STAGES];

`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_r;

   // Stall counter: flush clear wins over a same-cycle increment.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (flush) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (out_vld && !out_rdy) begin
         stall_cnt_r <= stall_sat_inc(stall_cnt_r);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   // Without the stall counter the pipe is the slice chain alone.
`endif

endmodule

// File: tb/tb_nv_nvdla_skid_pipe_n.sv
// Self-checking bench: queue scoreboard plus directed latency, streaming,
// backpressure, random and flush phases; stall counter when the macro is set.
module tb_nv_nvdla_skid_pipe_n;

   localparam int DW     = 16;
   localparam int STAGES = 2;
   localparam int CAP    = 2 * STAGES;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_vld;
   logic          in_rdy;
   logic [DW-1:0] in_pd;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] out_pd;
   logic          flush;
`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   nv_nvdla_skid_pipe_n #(.DW(DW), .STAGES(STAGES)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .in_vld          (in_vld),
      .in_rdy          (in_rdy),
      .in_pd           (in_pd),
      .out_vld         (out_vld),
      .out_rdy         (out_rdy),
      .out_pd          (out_pd),
      .flush           (flush)
`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
      ,
      .stall_cnt       (stall_cnt)
`endif
   );

   int            n_vec = 0;
   int            n_bad = 0;
   logic [DW-1:0] sb_q[$];
   logic [31:0]   model_stall = 32'd0;
   int            cyc = 0;
   int            first_pop = -1;
   int            last_pop = -1;
   int            n_acc = 0;
   int            n_pop = 0;
   logic          acc;
   logic          popped;
   logic          seen_vld;
   logic          seen_rdy;
   logic [DW-1:0] seen_pd;
   logic [31:0]   seen_stall = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: check registered outputs, drive inputs, advance the model to
   // the state the next rising edge will produce.
   task automatic tick(input logic v, input logic [DW-1:0] pd, input logic ordy, input logic fl);
      logic [DW-1:0] exp_pd;
      @(negedge clk);
      cyc++;
      seen_vld = out_vld;
      seen_rdy = in_rdy;
      seen_pd  = out_pd;
      if (sb_q.size() == 0) chk("vld_when_empty", 64'(out_vld), 64'(1'b0));
      chk("occupancy_le_cap", 64'(sb_q.size() <= CAP), 64'(1'b1));
`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
      seen_stall = stall_cnt;
      chk("stall_cnt", 64'(stall_cnt), 64'(model_stall));
`endif
      in_vld  = v;
      in_pd   = pd;
      out_rdy = ordy;
      flush   = fl;
      acc     = v && in_rdy;
      popped  = out_vld && ordy;
      if (acc) n_acc++;
      if (popped && sb_q.size() > 0) begin
         exp_pd = sb_q.pop_front();
         chk("out_pd_order", 64'(out_pd), 64'(exp_pd));
         n_pop++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (acc && !fl) sb_q.push_back(pd);
      if (fl) sb_q.delete();
      if (fl) model_stall = 32'd0;
      else if (out_vld && !ordy && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 32'd1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn    = 1'b0;
      in_vld  = 1'b0;
      in_pd   = '0;
      out_rdy = 1'b0;
      flush   = 1'b0;
      sb_q.delete();
      model_stall = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_in_rdy", 64'(in_rdy), 64'(1'b1));
      chk("rst_out_vld", 64'(out_vld), 64'(1'b0));
`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
      chk("rst_stall_cnt", 64'(stall_cnt), 64'(32'd0));
`endif
      rstn = 1'b1;
   endtask

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rstn    = 1'b0;
      in_vld  = 1'b0;
      in_pd   = '0;
      out_rdy = 1'b0;
      flush   = 1'b0;
      do_reset();

      // Latency from accept to out_vld on an empty pipe.
      tick(1'b1, 16'h01A5, 1'b1, 1'b0);
      chk("lat_accept", 64'(acc), 64'(1'b1));
      c = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1'b0, 16'h0000, 1'b1, 1'b0);
         if (seen_vld) begin
            c = i;
            break;
         end
      end
      chk("latency_cycles", 64'(c), 64'(STAGES));
      chk("latency_pd", 64'(seen_pd), 64'(16'h01A5));

      // Streaming 0..99 back to back.
      n_acc = 0; n_pop = 0; first_pop = -1; last_pop = -1;
      c = cyc + 1;
      for (int i = 0; i < 100; i++) tick(1'b1, DW'(i), 1'b1, 1'b0);
      repeat (STAGES + 4) tick(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("stream_accepts", 64'(n_acc), 64'(100));
      chk("stream_outputs", 64'(n_pop), 64'(100));
      chk("stream_first_out", 64'(first_pop - c), 64'(STAGES));
      chk("stream_span", 64'(last_pop - first_pop), 64'(99));

      // Backpressure: capacity, then recovery of in_rdy.
      n_acc = 0;
      for (int i = 0; i < 10; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
      chk("bp_accepts", 64'(n_acc), 64'(CAP));
      chk("bp_in_rdy_low", 64'(seen_rdy), 64'(1'b0));
      n_pop = 0;
      c = 99;
      for (int i = 1; i <= 20; i++) begin
         tick(1'b0, 16'h0000, 1'b1, 1'b0);
         if (seen_rdy) begin
            c = i - 1;
            break;
         end
      end
      chk("bp_recover_le_stages", 64'(c <= STAGES), 64'(1'b1));
      repeat (CAP + 4) tick(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("bp_drained", 64'(n_pop), 64'(CAP));

      // Random traffic, 50% valid / 50% ready.
      n_acc = 0; n_pop = 0;
      for (int i = 0; i < 10000; i++)
         tick(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      repeat (CAP * 3) tick(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("rand_all_delivered", 64'(n_pop), 64'(n_acc));
      chk("rand_queue_empty", 64'(sb_q.size()), 64'(0));
      chk("rand_in_rdy_idle", 64'(seen_rdy), 64'(1'b1));

      // Flush with three held entries and a beat offered in the flush cycle.
      n_acc = 0;
      for (int i = 0; i < 3; i++) tick(1'b1, DW'(16'h0A00 + i), 1'b0, 1'b0);
      chk("flush_fill", 64'(n_acc), 64'(3));
      tick(1'b1, 16'hBEEF, 1'b0, 1'b1);
      chk("flush_cycle_accept", 64'(acc), 64'(1'b1));
      n_pop = 0;
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("flush_out_vld", 64'(seen_vld), 64'(1'b0));
      chk("flush_in_rdy", 64'(seen_rdy), 64'(1'b1));
      repeat (CAP + 4) tick(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("flush_nothing_out", 64'(n_pop), 64'(0));

`ifdef NVDLA_SKID_PIPE_STALL_CNT_EN
      // Seven stalled cycles, then flush, then saturation.
      tick(1'b1, 16'h0077, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 16'h0000, 1'b0, 1'b0);
         if (seen_vld) break;
      end
      repeat (6) tick(1'b0, 16'h0000, 1'b0, 1'b0);
      tick(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("stall_seven", 64'(seen_stall), 64'(32'd7));
      tick(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("stall_flush_clear", 64'(seen_stall), 64'(32'd0));
      tick(1'b1, 16'h0078, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 16'h0000, 1'b0, 1'b0);
         if (seen_vld) break;
      end
      @(posedge clk);
      #1;
      force dut.stall_cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_r;
      model_stall = 32'hFFFF_FFFE;
      repeat (4) tick(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("stall_saturate", 64'(seen_stall), 64'(32'hFFFF_FFFF));
`endif

      do_reset();
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("final_in_rdy", 64'(seen_rdy), 64'(1'b1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
